// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving N req/gnt masters turns on one shared slave.
// Ports: clk/reset_n, m_* master side, s_* slave side, arb_busy/arb_owner status.
package design_params_pkg;
  parameter int P_ADDR_WIDTH = 32;
  parameter int P_DATA_WIDTH = 32;
endpackage

module bus_arbiter
  import design_params_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 16,
  parameter logic [P_DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF,
  localparam int OW = $clog2(N_MASTERS),
  localparam int WW = $clog2(TIMEOUT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_MASTERS-1:0]           m_req,
  input  logic [N_MASTERS-1:0]           m_write_en,
  input  logic [N_MASTERS*P_ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS*P_DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]           m_gnt,
  output logic [P_DATA_WIDTH-1:0]        m_rdata,
  output logic                           m_err,
  output logic                           s_req,
  output logic [P_ADDR_WIDTH-1:0]        s_addr,
  output logic [P_DATA_WIDTH-1:0]        s_wdata,
  output logic                           s_write_en,
  input  logic                           s_gnt,
  input  logic [P_DATA_WIDTH-1:0]        s_rdata,
  output logic                           arb_busy,
  output logic [OW-1:0]                  arb_owner
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [OW-1:0] O_LAST  = OW'(N_MASTERS - 1);

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [WW-1:0] wd_q, wd_d;

  logic [OW-1:0] pick_idx;
  logic          pick_vld;
  logic [OW-1:0] owner_nxt;
  int            pick_i;

  // Scan from the far end so the requester closest to rr_q wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    pick_i   = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      pick_i = (int'(rr_q) + k) % N_MASTERS;
      if (m_req[pick_i]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(pick_i);
      end
    end
  end

  assign owner_nxt = (owner_q == O_LAST) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    wd_d       = wd_q;
    m_gnt      = '0;
    m_rdata    = '0;
    m_err      = 1'b0;
    s_req      = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_write_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_req      = m_req[owner_q];
        s_write_en = m_write_en[owner_q];
        s_addr     = m_addr[int'(owner_q)*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        s_wdata    = m_wdata[int'(owner_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
        if (s_gnt) begin
          m_gnt[owner_q] = 1'b1;
          m_rdata        = s_rdata;
          rr_d           = owner_nxt;
          state_d        = IDLE;
        end else if (wd_q == WD_LAST) begin
          m_gnt[owner_q] = 1'b1;
          m_err          = 1'b1;
          m_rdata        = TIMEOUT_RDATA;
          rr_d           = owner_nxt;
          state_d        = IDLE;
        end else if (!m_req[owner_q]) begin
          rr_d    = owner_nxt;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A transaction caught by reset is dropped silently.
    if (!reset_n) begin
      m_gnt      = '0;
      m_rdata    = '0;
      m_err      = 1'b0;
      s_req      = 1'b0;
      s_addr     = '0;
      s_wdata    = '0;
      s_write_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  assign arb_busy  = (state_q == BUSY);
  assign arb_owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Random-stimulus bench for bus_arbiter against a transaction-level model.
// Ports: drives all master/slave inputs, checks every output each cycle.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int NCYC = 1500;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_write_en;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            s_req;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_write_en;
  logic            s_gnt;
  logic [DW-1:0]   s_rdata;
  logic            arb_busy;
  logic [1:0]      arb_owner;

  bus_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT(TO),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_write_en(m_write_en),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_write_en(s_write_en), .s_gnt(s_gnt), .s_rdata(s_rdata),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ok     = 0;
  int n_to     = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // Transaction-level model: who holds the bus, for how long,
  // and where the round-robin search starts next.
  bit mb;
  int mo, mptr, mage;

  function automatic int winner(input logic [N-1:0] rq, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - p + N) % N;
      if (rq[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  logic [N-1:0]  last_gnt;
  logic [N-1:0]  e_gnt;
  logic [DW-1:0] e_rdata;
  logic          e_err, e_sreq, e_swe;
  logic [AW-1:0] e_saddr;
  logic [DW-1:0] e_swd;
  bit            dead;

  initial begin
    reset_n    = 1'b0;
    m_req      = '0;
    m_write_en = '0;
    m_addr     = '0;
    m_wdata    = '0;
    s_gnt      = 1'b0;
    s_rdata    = '0;
    last_gnt   = '0;
    mb = 0; mo = 0; mptr = 0; mage = 0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset_n = !(cyc < 3 || cyc == 700 || cyc == 701);
      dead    = (cyc >= 200 && cyc < 420) || (cyc >= 1000 && cyc < 1100);
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) begin
          m_req[i] = 1'b0;
        end else if (!m_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            m_req[i]          = 1'b1;
            m_write_en[i]     = 1'($urandom);
            m_addr[i*AW +: AW]  = $urandom;
            m_wdata[i*DW +: DW] = $urandom;
          end
        end else if ($urandom_range(0, 79) == 0) begin
          m_req[i] = 1'b0;
        end
      end
      s_gnt   = !dead && ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      #2;

      e_gnt = '0; e_rdata = '0; e_err = 0;
      e_sreq = 0; e_swe = 0; e_saddr = '0; e_swd = '0;
      if (reset_n && mb) begin
        e_sreq  = m_req[mo];
        e_swe   = m_write_en[mo];
        e_saddr = m_addr[mo*AW +: AW];
        e_swd   = m_wdata[mo*DW +: DW];
        if (s_gnt) begin
          e_gnt[mo] = 1'b1;
          e_rdata   = s_rdata;
        end else if (mage == TO - 1) begin
          e_gnt[mo] = 1'b1;
          e_err     = 1'b1;
          e_rdata   = 32'hDEAD_BEEF;
        end
      end

      if (cyc >= 3) begin
        chk("arb_busy",  64'(arb_busy),   64'(mb));
        chk("arb_owner", 64'(arb_owner),  64'(mo));
        chk("s_req",     64'(s_req),      64'(e_sreq));
        chk("s_addr",    64'(s_addr),     64'(e_saddr));
        chk("s_wdata",   64'(s_wdata),    64'(e_swd));
        chk("s_we",      64'(s_write_en), 64'(e_swe));
        chk("m_gnt",     64'(m_gnt),      64'(e_gnt));
        chk("m_err",     64'(m_err),      64'(e_err));
        chk("m_rdata",   64'(m_rdata),    64'(e_rdata));
        if (|e_gnt && !e_err) n_ok++;
        if (e_err) n_to++;
      end

      last_gnt = e_gnt;
      if (!reset_n) begin
        mb = 0; mo = 0; mptr = 0; mage = 0;
      end else if (!mb) begin
        if (|m_req) begin
          mo   = winner(m_req, mptr);
          mage = 0;
          mb   = 1;
        end
      end else if (s_gnt || mage == TO - 1 || !m_req[mo]) begin
        mb   = 0;
        mptr = (mo + 1) % N;
      end else begin
        mage++;
      end
    end

    $display("completions=%0d timeouts=%0d", n_ok, n_to);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
